// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared constants and helpers for the architectural register
//                file and its operand lookup logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int REG_BIT      = 5;
    localparam int DEF_REG_NUM  = 32;
    localparam int DEF_ROB_BIT  = 4;
    localparam int DEF_ROB_SIZE = 1 << DEF_ROB_BIT;
    localparam int XLEN         = 32;

    // x0 is hardwired to zero: never written, always reads as zero
    function automatic logic is_x0(input logic [REG_BIT-1:0] id);
        return (id == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_if
//  Description : Issue, commit and operand-lookup bundle between the
//                register file and the ROB / decoder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int ROB_BIT = DEF_ROB_BIT
) ();

    logic                rdy_in;
    logic                clear_up;

    logic                issue_pollute;
    logic [REG_BIT-1:0]  issue_reg_id;
    logic [ROB_BIT-1:0]  issue_rob_entry;

    logic                rob_commit;
    logic [REG_BIT-1:0]  commit_rd_reg_id;
    logic [ROB_BIT-1:0]  commit_rob_entry;
    logic [XLEN-1:0]     commit_value;

    logic [REG_BIT-1:0]  rs1_id;
    logic [REG_BIT-1:0]  rs2_id;
    logic [ROB_BIT-1:0]  get_rob_entry1;
    logic [ROB_BIT-1:0]  get_rob_entry2;
    logic                ready1;
    logic                ready2;
    logic [XLEN-1:0]     value1;
    logic [XLEN-1:0]     value2;

    logic                rs1_busy;
    logic                rs2_busy;
    logic [XLEN-1:0]     rs1_val;
    logic [XLEN-1:0]     rs2_val;
    logic [ROB_BIT-1:0]  rs1_tag;
    logic [ROB_BIT-1:0]  rs2_tag;

    // ROB / decoder side
    modport master (
        output rdy_in, clear_up,
        output issue_pollute, issue_reg_id, issue_rob_entry,
        output rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
        output rs1_id, rs2_id, ready1, ready2, value1, value2,
        input  get_rob_entry1, get_rob_entry2,
        input  rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
    );

    // register file side
    modport slave (
        input  rdy_in, clear_up,
        input  issue_pollute, issue_reg_id, issue_rob_entry,
        input  rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
        input  rs1_id, rs2_id, ready1, ready2, value1, value2,
        output get_rob_entry1, get_rob_entry2,
        output rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
    );

endinterface
`default_nettype wire

// File: rtl/reg_operand_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : reg_operand_resolve
//  Description : Combinational resolution of one source operand into either
//                a value (register, commit bypass or ROB forward) or a
//                pending producer tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_operand_resolve
    import reg_file_pkg::*;
#(
    parameter int ROB_BIT = DEF_ROB_BIT
) (
    input  logic [REG_BIT-1:0]  rs_id,
    input  logic                reg_busy,
    input  logic [ROB_BIT-1:0]  reg_tag,
    input  logic [XLEN-1:0]     reg_val,
    input  logic                rob_commit,
    input  logic [ROB_BIT-1:0]  commit_rob_entry,
    input  logic [XLEN-1:0]     commit_value,
    input  logic                rob_ready,
    input  logic [XLEN-1:0]     rob_value,
    output logic [ROB_BIT-1:0]  get_rob_entry,
    output logic                rs_busy,
    output logic [XLEN-1:0]     rs_val,
    output logic [ROB_BIT-1:0]  rs_tag
);

    // priority: x0, idle register, commit bypass, ROB forward, still pending
    always_comb begin
        get_rob_entry = reg_tag;
        rs_busy       = 1'b0;
        rs_val        = '0;
        rs_tag        = '0;
        if (is_x0(rs_id)) begin
            rs_val = '0;
        end else if (!reg_busy) begin
            rs_val = reg_val;
        end else if (rob_commit && (commit_rob_entry == reg_tag)) begin
            rs_val = commit_value;
        end else if (rob_ready) begin
            rs_val = rob_value;
        end else begin
            rs_busy = 1'b1;
            rs_tag  = reg_tag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : Architectural register file with rename tags. Tracks the
//                ROB entry producing each register, absorbs committed values
//                and resolves two decoder source operands per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_BIT = DEF_ROB_BIT,
    parameter int REG_NUM = DEF_REG_NUM
) (
    input  logic         clk_in,
    input  logic         rst_in,
    reg_file_if.slave    bus
);

    logic [XLEN-1:0]    val_q  [REG_NUM];
    logic [ROB_BIT-1:0] tag_q  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic commit_en;
    logic commit_match;
    logic issue_en;

    assign commit_en    = bus.rob_commit && !is_x0(bus.commit_rd_reg_id);
    assign commit_match = busy_q[bus.commit_rd_reg_id]
                          && (tag_q[bus.commit_rd_reg_id] == bus.commit_rob_entry);
    assign issue_en     = bus.issue_pollute && !is_x0(bus.issue_reg_id) && !bus.clear_up;

    // commit, then issue, then flush; later statements win on conflicts
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (bus.rdy_in) begin
            if (commit_en) begin
                val_q[bus.commit_rd_reg_id] <= bus.commit_value;
                // a younger writer keeps the register renamed
                if (commit_match) begin
                    busy_q[bus.commit_rd_reg_id] <= 1'b0;
                end
            end
            if (issue_en) begin
                busy_q[bus.issue_reg_id] <= 1'b1;
                tag_q[bus.issue_reg_id]  <= bus.issue_rob_entry;
            end
            // tags are left stale; busy=0 makes them irrelevant
            if (bus.clear_up) begin
                busy_q <= '0;
            end
        end
    end

    reg_operand_resolve #(.ROB_BIT(ROB_BIT)) u_rs1 (
        .rs_id            (bus.rs1_id),
        .reg_busy         (busy_q[bus.rs1_id]),
        .reg_tag          (tag_q[bus.rs1_id]),
        .reg_val          (val_q[bus.rs1_id]),
        .rob_commit       (bus.rob_commit),
        .commit_rob_entry (bus.commit_rob_entry),
        .commit_value     (bus.commit_value),
        .rob_ready        (bus.ready1),
        .rob_value        (bus.value1),
        .get_rob_entry    (bus.get_rob_entry1),
        .rs_busy          (bus.rs1_busy),
        .rs_val           (bus.rs1_val),
        .rs_tag           (bus.rs1_tag)
    );

    reg_operand_resolve #(.ROB_BIT(ROB_BIT)) u_rs2 (
        .rs_id            (bus.rs2_id),
        .reg_busy         (busy_q[bus.rs2_id]),
        .reg_tag          (tag_q[bus.rs2_id]),
        .reg_val          (val_q[bus.rs2_id]),
        .rob_commit       (bus.rob_commit),
        .commit_rob_entry (bus.commit_rob_entry),
        .commit_value     (bus.commit_value),
        .rob_ready        (bus.ready2),
        .rob_value        (bus.value2),
        .get_rob_entry    (bus.get_rob_entry2),
        .rs_busy          (bus.rs2_busy),
        .rs_val           (bus.rs2_val),
        .rs_tag           (bus.rs2_tag)
    );

endmodule
`default_nettype wire
